// File: rtl/mem_block_responder_if.sv
// Request / backing-read / response bundle of the block responder.
// "slave" is the responder side; "master" is the cache plus backing-memory side.
interface mem_block_responder_if #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] i_req_addr;
    logic                  i_req_valid;
    logic                  o_req_ready;
    logic                  o_rd_en;
    logic [ADDR_WIDTH-1:0] o_rd_addr;
    logic [DATA_WIDTH-1:0] i_rd_data;
    logic [DATA_WIDTH-1:0] o_data;
    logic                  o_data_valid;
    logic                  o_data_last;
    logic                  i_data_ready;
    logic                  o_busy;

    modport slave (
        input  i_req_addr, i_req_valid, i_rd_data, i_data_ready,
        output o_req_ready, o_rd_en, o_rd_addr, o_data, o_data_valid, o_data_last, o_busy
    );

    modport master (
        output i_req_addr, i_req_valid, i_rd_data, i_data_ready,
        input  o_req_ready, o_rd_en, o_rd_addr, o_data, o_data_valid, o_data_last, o_busy
    );
endinterface

// File: rtl/mem_block_responder.sv
// Streams one cache block of beats from a synchronous backing memory per request.
// Define MEM_RESP_STATS_EN to add saturating request/stall counters.
module mem_block_responder #(
    parameter int ADDR_WIDTH       = 16,
    parameter int DATA_WIDTH       = 32,
    parameter int BLK_OFFSET_WIDTH = 4,
    parameter int BEATS_PER_BLOCK  = 10,
    parameter int ACCESS_LATENCY   = 4
) (
    input  logic                 clk,
    input  logic                 arst_n,
    mem_block_responder_if.slave resp_if
`ifdef MEM_RESP_STATS_EN
    ,
    output logic [15:0]          o_req_count,
    output logic [15:0]          o_stall_count
`endif
);
    localparam int BlkW = ADDR_WIDTH - BLK_OFFSET_WIDTH;
    localparam int CntW = $clog2(BEATS_PER_BLOCK + 1);
    localparam int LatW = (ACCESS_LATENCY > 2) ? $clog2(ACCESS_LATENCY) : 1;

    typedef enum logic [1:0] {StIdle, StWait, StStream} state_e;

    state_e                state_q, state_d;
    logic [BlkW-1:0]       blk_q, blk_d;
    logic [LatW-1:0]       lat_q, lat_d;
    logic [CntW-1:0]       issued_q, issued_d;
    logic [CntW-1:0]       beat_q, beat_d;
    logic                  rd_valid_q;
    logic                  up_q;
    logic [DATA_WIDTH-1:0] buf_q [2];
    logic                  wr_ptr_q, rd_ptr_q;
    logic [1:0]            buf_cnt_q;

    logic                  accept, buf_empty, data_valid, pop, pop_buf, push, last_beat, rd_en;
    logic [2:0]            occ;
    logic [ADDR_WIDTH-1:0] rd_addr_calc;
    logic                  unused_offset;

    assign unused_offset = ^resp_if.i_req_addr[BLK_OFFSET_WIDTH-1:0];

    assign accept     = resp_if.i_req_valid & resp_if.o_req_ready;
    assign buf_empty  = (buf_cnt_q == 2'd0);
    // An empty buffer forwards the arriving read beat directly to keep the first-beat latency.
    assign data_valid = ~buf_empty | rd_valid_q;
    assign pop        = data_valid & resp_if.i_data_ready;
    assign pop_buf    = pop & ~buf_empty;
    assign push       = rd_valid_q & ~(pop & buf_empty);
    assign last_beat  = (beat_q == CntW'(BEATS_PER_BLOCK - 1));
    assign occ        = 3'(buf_cnt_q) + 3'(rd_valid_q) - 3'(pop);
    assign rd_en      = (state_q == StStream) && (issued_q < CntW'(BEATS_PER_BLOCK)) &&
                        (occ < 3'd2);
    assign rd_addr_calc = ADDR_WIDTH'(blk_q) * ADDR_WIDTH'(BEATS_PER_BLOCK) +
                          ADDR_WIDTH'(issued_q);

    assign resp_if.o_req_ready  = (state_q == StIdle) & up_q;
    assign resp_if.o_busy       = (state_q != StIdle);
    assign resp_if.o_rd_en      = rd_en;
    assign resp_if.o_rd_addr    = rd_en ? rd_addr_calc : '0;
    assign resp_if.o_data_valid = data_valid;
    assign resp_if.o_data_last  = data_valid & last_beat;
    assign resp_if.o_data       = !buf_empty ? buf_q[rd_ptr_q] :
                                  (rd_valid_q ? resp_if.i_rd_data : '0);

    always_comb begin
        state_d  = state_q;
        blk_d    = blk_q;
        lat_d    = lat_q;
        issued_d = issued_q + CntW'(rd_en);
        beat_d   = beat_q + CntW'(pop);
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    blk_d = resp_if.i_req_addr[ADDR_WIDTH-1:BLK_OFFSET_WIDTH];
                    if (ACCESS_LATENCY == 0) begin
                        state_d = StStream;
                    end else begin
                        state_d = StWait;
                        lat_d   = LatW'(ACCESS_LATENCY - 1);
                    end
                end
            end
            StWait: begin
                if (lat_q == '0) state_d = StStream;
                else             lat_d   = lat_q - 1'b1;
            end
            StStream: begin
                if (pop && last_beat) begin
                    state_d  = StIdle;
                    issued_d = '0;
                    beat_d   = '0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q    <= StIdle;
            blk_q      <= '0;
            lat_q      <= '0;
            issued_q   <= '0;
            beat_q     <= '0;
            rd_valid_q <= 1'b0;
            up_q       <= 1'b0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            buf_cnt_q  <= 2'd0;
            for (int i = 0; i < 2; i++) buf_q[i] <= '0;
        end else begin
            state_q    <= state_d;
            blk_q      <= blk_d;
            lat_q      <= lat_d;
            issued_q   <= issued_d;
            beat_q     <= beat_d;
            rd_valid_q <= rd_en;
            up_q       <= 1'b1;
            if (push) begin
                buf_q[wr_ptr_q] <= resp_if.i_rd_data;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop_buf) rd_ptr_q <= ~rd_ptr_q;
            buf_cnt_q <= buf_cnt_q + 2'(push) - 2'(pop_buf);
        end
    end

`ifdef MEM_RESP_STATS_EN
    logic [15:0] req_cnt_q, stall_cnt_q;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            req_cnt_q   <= '0;
            stall_cnt_q <= '0;
        end else begin
            if (accept && req_cnt_q != 16'hFFFF) req_cnt_q <= req_cnt_q + 16'd1;
            if (data_valid && !resp_if.i_data_ready && stall_cnt_q != 16'hFFFF) begin
                stall_cnt_q <= stall_cnt_q + 16'd1;
            end
        end
    end

    assign o_req_count   = req_cnt_q;
    assign o_stall_count = stall_cnt_q;
`endif
endmodule

// File: tb/tb_mem_block_responder.sv
// Directed bench for mem_block_responder: a latency-4 instance and a latency-0 instance.
// Stats counters are checked when MEM_RESP_STATS_EN is defined.
module tb_mem_block_responder;
    localparam int B = 10;

    logic clk = 1'b0;
    logic arst_n = 1'b1;
    always #5 clk = ~clk;

    mem_block_responder_if #(.ADDR_WIDTH(16), .DATA_WIDTH(32)) busa ();
    mem_block_responder_if #(.ADDR_WIDTH(16), .DATA_WIDTH(32)) busb ();

    logic        sel = 1'b0;
    logic        req_valid = 1'b0;
    logic        data_ready = 1'b1;
    logic [15:0] req_addr = 16'h0;
    logic [31:0] rd_data_a = 32'h0;
    logic [31:0] rd_data_b = 32'h0;

    assign busa.i_req_addr   = req_addr;
    assign busb.i_req_addr   = req_addr;
    assign busa.i_req_valid  = req_valid & ~sel;
    assign busb.i_req_valid  = req_valid & sel;
    assign busa.i_data_ready = data_ready;
    assign busb.i_data_ready = data_ready;
    assign busa.i_rd_data    = rd_data_a;
    assign busb.i_rd_data    = rd_data_b;

`ifdef MEM_RESP_STATS_EN
    logic [15:0] unused_req_cnt_a, unused_stall_cnt_a, req_cnt_b, stall_cnt_b;
`endif

    mem_block_responder #(.ACCESS_LATENCY(4)) dut_a (
        .clk     (clk),
        .arst_n  (arst_n),
        .resp_if (busa)
`ifdef MEM_RESP_STATS_EN
        ,
        .o_req_count   (unused_req_cnt_a),
        .o_stall_count (unused_stall_cnt_a)
`endif
    );

    mem_block_responder #(.ACCESS_LATENCY(0)) dut_b (
        .clk     (clk),
        .arst_n  (arst_n),
        .resp_if (busb)
`ifdef MEM_RESP_STATS_EN
        ,
        .o_req_count   (req_cnt_b),
        .o_stall_count (stall_cnt_b)
`endif
    );

    function automatic logic [31:0] mem_f(input logic [15:0] a);
        return {a ^ 16'hC35A, a};
    endfunction

    // Synchronous backing memory: data the cycle after the read strobe.
    always @(posedge clk) begin
        if (busa.o_rd_en) rd_data_a <= mem_f(busa.o_rd_addr);
        if (busb.o_rd_en) rd_data_b <= mem_f(busb.o_rd_addr);
    end

    logic        obs_ready, obs_rd_en, obs_valid, obs_last, obs_busy;
    logic [15:0] obs_rd_addr;
    logic [31:0] obs_data;
    logic [1:0]  obs_buf;
    assign obs_ready   = sel ? busb.o_req_ready  : busa.o_req_ready;
    assign obs_rd_en   = sel ? busb.o_rd_en      : busa.o_rd_en;
    assign obs_rd_addr = sel ? busb.o_rd_addr    : busa.o_rd_addr;
    assign obs_valid   = sel ? busb.o_data_valid : busa.o_data_valid;
    assign obs_last    = sel ? busb.o_data_last  : busa.o_data_last;
    assign obs_data    = sel ? busb.o_data       : busa.o_data;
    assign obs_busy    = sel ? busb.o_busy       : busa.o_busy;
    assign obs_buf     = sel ? dut_b.buf_cnt_q   : dut_a.buf_cnt_q;

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Caller sits between edges; request is accepted on the next posedge.
    task automatic directed_stream(input logic [15:0] addr, input int lat, input bit hold);
        int  base;
        bit  exp_en, exp_v;
        base      = int'(addr[15:4]) * B;
        req_addr  = addr;
        req_valid = 1'b1;
        #1;
        check("req_ready_pre", 32'(obs_ready), 32'd1);
        @(posedge clk);
        #1;
        req_valid = hold;
        for (int k = 1; k <= lat + B + 2; k++) begin
            @(negedge clk);
            exp_en = (k >= lat + 1) && (k <= lat + B);
            exp_v  = (k >= lat + 2) && (k <= lat + B + 1);
            check("rd_en", 32'(obs_rd_en), 32'(exp_en));
            if (exp_en) check("rd_addr", 32'(obs_rd_addr), 32'(base + k - lat - 1));
            check("data_valid", 32'(obs_valid), 32'(exp_v));
            if (exp_v) begin
                check("data", obs_data, mem_f(16'(base + k - lat - 2)));
                check("data_last", 32'(obs_last), 32'(k == lat + B + 1));
            end
            check("req_ready", 32'(obs_ready), 32'(k == lat + B + 2));
            check("busy", 32'(obs_busy), 32'(k != lat + B + 2));
        end
    endtask

    function automatic logic rdy_at(input int k, input int stall_until);
        if (stall_until > 0) return k > stall_until;
        return (k % 4 == 0) || (k % 4 == 1);
    endfunction

    task automatic bp_stream(input logic [15:0] addr, input int stall_until);
        int base;
        int idx;
        int cyc;
        base      = int'(addr[15:4]) * B;
        idx       = 0;
        cyc       = 0;
        req_addr  = addr;
        req_valid = 1'b1;
        #1;
        check("bp_req_ready_pre", 32'(obs_ready), 32'd1);
        @(posedge clk);
        #1;
        req_valid  = 1'b0;
        data_ready = rdy_at(1, stall_until);
        while (idx < B && cyc < 200) begin
            cyc++;
            @(negedge clk);
            check("buf_le2", 32'(obs_buf <= 2'd2), 32'd1);
            check("bp_req_ready", 32'(obs_ready), 32'd0);
            if (obs_valid) begin
                check("bp_data", obs_data, mem_f(16'(base + idx)));
                check("bp_last", 32'(obs_last), 32'(idx == B - 1));
                if (data_ready) idx++;
            end
            @(posedge clk);
            #1;
            data_ready = rdy_at(cyc + 1, stall_until);
        end
        check("bp_beats", 32'(idx), 32'(B));
        @(negedge clk);
        check("bp_idle_ready", 32'(obs_ready), 32'd1);
        data_ready = 1'b1;
    endtask

    initial begin
        #2 arst_n = 1'b0;
        #10;
        check("rst_ready", 32'(busa.o_req_ready), 32'd0);
        check("rst_rd_en", 32'(busa.o_rd_en), 32'd0);
        check("rst_valid", 32'(busa.o_data_valid), 32'd0);
        check("rst_busy", 32'(busa.o_busy), 32'd0);
        check("rst_data", busa.o_data, 32'd0);
        #10 arst_n = 1'b1;
        #1;
        check("ready_before_edge", 32'(busa.o_req_ready), 32'd0);
        @(posedge clk);
        #1;
        check("ready_after_edge", 32'(busa.o_req_ready), 32'd1);

        directed_stream(16'h0000, 4, 1'b0);
        directed_stream(16'h123F, 4, 1'b0);
        bp_stream(16'h0070, 0);
        directed_stream(16'h0020, 4, 1'b1);
        directed_stream(16'h0031, 4, 1'b0);

        // Reset while the fifth beat is presented.
        req_addr  = 16'h0000;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        repeat (10) @(negedge clk);
        check("pre_rst_valid", 32'(busa.o_data_valid), 32'd1);
        arst_n = 1'b0;
        #1;
        check("mid_rst_ready", 32'(busa.o_req_ready), 32'd0);
        check("mid_rst_rd_en", 32'(busa.o_rd_en), 32'd0);
        check("mid_rst_rd_addr", 32'(busa.o_rd_addr), 32'd0);
        check("mid_rst_data", busa.o_data, 32'd0);
        check("mid_rst_valid", 32'(busa.o_data_valid), 32'd0);
        check("mid_rst_last", 32'(busa.o_data_last), 32'd0);
        check("mid_rst_busy", 32'(busa.o_busy), 32'd0);
        @(posedge clk);
        @(negedge clk);
        check("held_rst_valid", 32'(busa.o_data_valid), 32'd0);
        arst_n = 1'b1;
        @(posedge clk);
        #1;
        directed_stream(16'h0010, 4, 1'b0);

        // Zero-latency instance: two clean requests and one with seven stall cycles.
        @(posedge clk);
        #1;
        sel = 1'b1;
        directed_stream(16'h0030, 0, 1'b0);
        directed_stream(16'h0040, 0, 1'b0);
        bp_stream(16'h0050, 8);
`ifdef MEM_RESP_STATS_EN
        check("req_count", 32'(req_cnt_b), 32'd3);
        check("stall_count", 32'(stall_cnt_b), 32'd7);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
